// File: rtl/micro_tile_sched.sv
// micro_tile_sched: shares one IO bank among N_TILES micro tiles.
// One tile is active at a time. It is chosen either manually with a load
// strobe or automatically by round-robin over the tile requests, with a
// minimum dwell time in auto mode. Every switch blanks the outputs, holds
// the new tile in reset for RST_CYCLES, and then runs it.
module micro_tile_sched #(
    parameter int N_TILES    = 8,
    parameter int IDX_W      = 3,
    parameter int RST_CYCLES = 4,
    parameter int DWELL      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel_mode,
    input  logic                   sel_load,
    input  logic [IDX_W-1:0]       sel_idx,
    input  logic [N_TILES-1:0]     tile_req,
    input  logic [8*N_TILES-1:0]   tile_uo,
    output logic [N_TILES-1:0]     tile_ena,
    output logic [N_TILES-1:0]     tile_rst_n,
    output logic [7:0]             uo_out,
    output logic [IDX_W-1:0]       active_idx,
    output logic                   busy,
    output logic                   sel_err
);

    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int DW_W = $clog2(DWELL + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);
    localparam logic [DW_W-1:0] DW_MAX  = DW_W'(DWELL);

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SWITCH     = 2'd1,
        ST_RESET_TILE = 2'd2,
        ST_RUN        = 2'd3
    } state_t;

    state_t              state_r, next_state_s;
    logic [IDX_W-1:0]    target_r, next_target_s;
    logic [IDX_W-1:0]    rr_ptr_r, next_rr_ptr_s;
    logic [RC_W-1:0]     rst_cnt_r, next_rst_cnt_s;
    logic [DW_W-1:0]     dwell_r, next_dwell_s, dwell_inc_s;
    logic                mode_prev_r;
    logic [7:0]          uo_r;
    logic                sel_err_r, sel_err_s;
    logic [N_TILES-1:0]  ena_r, rst_n_r;
    logic                busy_r;
    logic                idx_valid_s, manual_ok_s;
    logic                do_switch_s;
    logic [IDX_W-1:0]    switch_idx_s;
    logic [IDX_W:0]      pick_s;
    logic [N_TILES-1:0]  active_oh_s;
    logic [7:0]          uo_sel_s;

    // One-hot decode; an index outside 0..N_TILES-1 decodes to all zeros.
    function automatic logic [N_TILES-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [N_TILES-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_TILES; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    // First requester scanning start, start+1, ... with wrap-around.
    // skip_start excludes start itself. The MSB of the result is the found flag.
    function automatic logic [IDX_W:0] rr_pick(input logic [N_TILES-1:0] req,
                                               input logic [IDX_W-1:0]   start,
                                               input logic               skip_start);
        logic [IDX_W:0] res;
        int j;
        res = '0;
        for (int k = 0; k < N_TILES; k++) begin
            j = (int'(start) + k) % N_TILES;
            if (!res[IDX_W] && req[j] && !(skip_start && (k == 0))) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    assign active_oh_s = idx_onehot(target_r);

    // Read-side mux: the active tile's output byte.
    always_comb begin
        uo_sel_s = 8'h00;
        for (int i = 0; i < N_TILES; i++) begin
            uo_sel_s = uo_sel_s | (tile_uo[8*i +: 8] & {8{active_oh_s[i]}});
        end
    end

    // Next-state logic: select acceptance, round-robin, dwell and reset counters.
    always_comb begin
        next_state_s   = state_r;
        next_target_s  = target_r;
        next_rst_cnt_s = rst_cnt_r;
        next_dwell_s   = dwell_r;
        do_switch_s    = 1'b0;
        switch_idx_s   = target_r;
        pick_s         = '0;
        idx_valid_s    = ({1'b0, sel_idx} < (IDX_W+1)'(N_TILES));
        manual_ok_s    = !sel_mode && sel_load && idx_valid_s;
        sel_err_s      = !sel_mode && sel_load && !idx_valid_s;
        dwell_inc_s    = (dwell_r == DW_MAX) ? DW_MAX : (dwell_r + 1'b1);

        case (state_r)
            ST_IDLE: begin
                if (manual_ok_s) begin
                    do_switch_s  = 1'b1;
                    switch_idx_s = sel_idx;
                end else if (sel_mode) begin
                    pick_s       = rr_pick(tile_req, rr_ptr_r, 1'b0);
                    do_switch_s  = pick_s[IDX_W];
                    switch_idx_s = pick_s[IDX_W-1:0];
                end else begin
                    do_switch_s  = 1'b0;
                end
            end
            ST_SWITCH: begin
                // A new manual target restarts the sequence from SWITCH.
                if (manual_ok_s) begin
                    do_switch_s  = 1'b1;
                    switch_idx_s = sel_idx;
                end else begin
                    next_state_s   = ST_RESET_TILE;
                    next_rst_cnt_s = '0;
                end
            end
            ST_RESET_TILE: begin
                if (manual_ok_s) begin
                    do_switch_s  = 1'b1;
                    switch_idx_s = sel_idx;
                end else if (rst_cnt_r == RC_LAST) begin
                    next_state_s = ST_RUN;
                    next_dwell_s = '0;
                end else begin
                    next_rst_cnt_s = rst_cnt_r + 1'b1;
                end
            end
            ST_RUN: begin
                if (manual_ok_s && (sel_idx != target_r)) begin
                    do_switch_s  = 1'b1;
                    switch_idx_s = sel_idx;
                end else if (sel_mode) begin
                    // Dwell restarts on the first auto cycle after manual mode.
                    pick_s       = rr_pick(tile_req, target_r, 1'b1);
                    switch_idx_s = pick_s[IDX_W-1:0];
                    next_dwell_s = mode_prev_r ? dwell_inc_s : '0;
                    do_switch_s  = pick_s[IDX_W] &&
                                   (!(|(tile_req & active_oh_s)) ||
                                    (mode_prev_r && (dwell_inc_s == DW_MAX)));
                end else begin
                    next_dwell_s = dwell_inc_s;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase

        if (do_switch_s) begin
            next_state_s  = ST_SWITCH;
            next_target_s = switch_idx_s;
            next_dwell_s  = '0;
        end else begin
            next_target_s = next_target_s;
        end
    end

    assign next_rr_ptr_s = do_switch_s ? switch_idx_s : rr_ptr_r;

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            target_r    <= '0;
            rr_ptr_r    <= '0;
            rst_cnt_r   <= '0;
            dwell_r     <= '0;
            mode_prev_r <= 1'b0;
            uo_r        <= 8'h00;
            sel_err_r   <= 1'b0;
            ena_r       <= '0;
            rst_n_r     <= '0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            target_r    <= next_target_s;
            rr_ptr_r    <= next_rr_ptr_s;
            rst_cnt_r   <= next_rst_cnt_s;
            dwell_r     <= next_dwell_s;
            mode_prev_r <= sel_mode;
            uo_r        <= (state_r == ST_RUN) ? uo_sel_s : 8'h00;
            sel_err_r   <= sel_err_s;
            ena_r       <= ((next_state_s == ST_RESET_TILE) || (next_state_s == ST_RUN)) ?
                           idx_onehot(next_target_s) : '0;
            rst_n_r     <= (next_state_s == ST_RUN) ? idx_onehot(next_target_s) : '0;
            busy_r      <= (next_state_s == ST_SWITCH) || (next_state_s == ST_RESET_TILE);
        end
    end

    assign tile_ena   = ena_r;
    assign tile_rst_n = rst_n_r;
    assign uo_out     = uo_r;
    assign active_idx = target_r;
    assign busy       = busy_r;
    assign sel_err    = sel_err_r;

endmodule

// File: tb/tb_micro_tile_sched.sv
// Directed bench for micro_tile_sched: manual select timing, reject,
// retarget, auto round-robin dwell, early switch, hold and mid-sequence reset.
module tb_micro_tile_sched;

    localparam int N  = 8;
    localparam int IW = 4;
    localparam int RC = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel_mode;
    logic            sel_load;
    logic [IW-1:0]   sel_idx;
    logic [N-1:0]    tile_req;
    logic [8*N-1:0]  tile_uo;
    logic [N-1:0]    tile_ena;
    logic [N-1:0]    tile_rst_n;
    logic [7:0]      uo_out;
    logic [IW-1:0]   active_idx;
    logic            busy;
    logic            sel_err;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_uo_q[$];
    int         exp_idx_q[$];

    micro_tile_sched #(.N_TILES(N), .IDX_W(IW), .RST_CYCLES(RC), .DWELL(DW)) dut (
        .clk(clk), .rst(rst), .sel_mode(sel_mode), .sel_load(sel_load),
        .sel_idx(sel_idx), .tile_req(tile_req), .tile_uo(tile_uo),
        .tile_ena(tile_ena), .tile_rst_n(tile_rst_n), .uo_out(uo_out),
        .active_idx(active_idx), .busy(busy), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tile_val(input int i);
        return (i == 5) ? 8'h3C : (8'h40 + 8'(i));
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until a tile is in RUN; returns cycles waited.
    task automatic wait_run(output int cyc);
        cyc = 0;
        while (!((busy == 1'b0) && (tile_rst_n != '0)) && (cyc < 40)) begin
            tick();
            cyc++;
        end
    endtask

    // Counts RUN cycles until the next SWITCH becomes visible (bounded).
    task automatic measure_run(output int len);
        len = 0;
        while ((busy == 1'b0) && (len < 100)) begin
            tick();
            len++;
        end
    endtask

    initial begin
        int w;
        int len;
        int cnt;
        logic saw2;
        logic got6;

        rst = 1'b1; sel_mode = 1'b0; sel_load = 1'b0; sel_idx = '0; tile_req = '0;
        tile_uo = {N{8'hAA}};
        @(negedge clk);
        tick();
        tick();
        check("rst_ena",   tile_ena,   8'h00);
        check("rst_rstn",  tile_rst_n, 8'h00);
        check("rst_uo",    uo_out,     8'h00);
        check("rst_busy",  busy,       1'b0);
        check("rst_idx",   active_idx, 4'd0);
        check("rst_err",   sel_err,    1'b0);

        rst = 1'b0;
        for (int i = 0; i < N; i++) tile_uo[8*i +: 8] = tile_val(i);
        tick();

        // Manual select of tile 5, checked cycle by cycle after edge T.
        sel_load = 1'b1; sel_idx = 4'd5;
        exp_uo_q.push_back(tile_val(5));
        tick();
        sel_load = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c <= 5) begin
                check("man_busy", busy, 1'b1);
                check("man_rstn_lo", tile_rst_n, 8'h00);
                check("man_ena", tile_ena, (c == 1) ? 8'h00 : 8'h20);
                check("man_uo_blank", uo_out, 8'h00);
            end else if (c == 6) begin
                check("man_busy_end", busy, 1'b0);
                check("man_rstn_hi", tile_rst_n, 8'h20);
                check("man_uo_lat", uo_out, 8'h00);
            end else begin
                check("man_uo", uo_out, exp_uo_q.pop_front());
            end
            check("man_idx", active_idx, 4'd5);
            if (c < 7) tick();
        end

        // Out-of-range load is rejected.
        sel_load = 1'b1; sel_idx = 4'd9;
        tick();
        sel_load = 1'b0;
        check("rej_err", sel_err, 1'b1);
        check("rej_idx", active_idx, 4'd5);
        check("rej_ena", tile_ena, 8'h20);
        check("rej_busy", busy, 1'b0);
        tick();
        check("rej_err_pulse", sel_err, 1'b0);
        check("rej_uo", uo_out, 8'h3C);

        // Reloading the running tile has no effect.
        sel_load = 1'b1; sel_idx = 4'd5;
        tick();
        sel_load = 1'b0;
        check("same_busy", busy, 1'b0);
        check("same_rstn", tile_rst_n, 8'h20);

        // Retarget from 2 to 6 during RESET_TILE.
        sel_load = 1'b1; sel_idx = 4'd2;
        tick();
        sel_load = 1'b0;
        check("rt_sw2_idx", active_idx, 4'd2);
        tick();
        tick();
        check("rt_ena2", tile_ena, 8'h04);
        sel_load = 1'b1; sel_idx = 4'd6;
        exp_uo_q.push_back(tile_val(6));
        tick();
        sel_load = 1'b0;
        check("rt_busy", busy, 1'b1);
        check("rt_idx", active_idx, 4'd6);
        check("rt_ena", tile_ena, 8'h00);
        saw2 = 1'b0; got6 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tile_rst_n[2]) saw2 = 1'b1;
            if (!got6) begin
                if (tile_rst_n[6]) got6 = 1'b1;
                else tick();
            end
        end
        check("rt_tile2_never", saw2, 1'b0);
        check("rt_tile6_runs", got6, 1'b1);
        tick();
        check("rt_uo", uo_out, exp_uo_q.pop_front());

        // Auto round-robin from reset: 0 -> 1 -> 3 -> 0, 16 RUN cycles each.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sel_mode = 1'b1;
        tile_req = 8'b0000_1011;
        exp_idx_q = {0, 1, 3, 0};
        for (int r = 0; r < 3; r++) begin
            wait_run(w);
            check("auto_wait", (w < 40), 1'b1);
            check("auto_idx", active_idx, exp_idx_q.pop_front());
            measure_run(len);
            check("auto_dwell", len, DW);
        end
        wait_run(w);
        check("auto_wrap_idx", active_idx, exp_idx_q.pop_front());
        measure_run(len);
        check("auto_dwell0", len, DW);

        // Early switch when tile 1 drops its request while tile 3 requests.
        wait_run(w);
        check("early_idx1", active_idx, 4'd1);
        tick(); tick(); tick();
        tile_req = 8'b0000_1001;
        tick();
        check("early_busy", busy, 1'b1);
        check("early_idx3", active_idx, 4'd3);
        check("early_ena", tile_ena, 8'h00);

        // All requests drop: tile 3 stays in RUN; sel_load ignored in auto.
        wait_run(w);
        check("hold_idx", active_idx, 4'd3);
        tile_req = '0;
        sel_load = 1'b1; sel_idx = 4'd9;
        tick();
        sel_load = 1'b0;
        check("auto_no_err", sel_err, 1'b0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if ((busy == 1'b0) && (tile_rst_n == 8'h08)) cnt++;
            tick();
        end
        check("hold_run", cnt, 40);

        // Auto to manual keeps the current tile.
        sel_mode = 1'b0;
        tick(); tick(); tick();
        check("a2m_busy", busy, 1'b0);
        check("a2m_rstn", tile_rst_n, 8'h08);

        // Reset in the middle of a switch sequence.
        sel_load = 1'b1; sel_idx = 4'd4;
        tick();
        sel_load = 1'b0;
        tick();
        tick();
        check("mid_ena", tile_ena, 8'h10);
        rst = 1'b1;
        tick();
        check("mid_rst_ena", tile_ena, 8'h00);
        check("mid_rst_rstn", tile_rst_n, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_idx", active_idx, 4'd0);
        rst = 1'b0;
        tick();
        check("mid_no_glitch", tile_ena, 8'h00);
        check("mid_uo", uo_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/micro_tile_sched.md
Name: micro_tile_sched

Overview:
- Controller that shares the container's single IO bank among N_TILES micro tiles.
- Selects exactly one active tile, either manually via a load strobe or automatically by round-robin over tile requests with a minimum dwell time.
- Sequences every switch: blank the outputs, hold the new tile in reset, then run it.
- Drives per-tile enable and reset lines, and returns the active tile's outputs through a registered mux.

Parameters:
- N_TILES, 8, number of micro tiles (2..16).
- IDX_W, 3, tile index width; must satisfy 2**IDX_W >= N_TILES.
- RST_CYCLES, 4, cycles the newly selected tile is held in reset (>=1).
- DWELL, 16, minimum RUN cycles before an auto-mode rotation (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- sel_mode  in  1  0 = manual, 1 = auto round-robin.
- sel_load  in  1  manual select strobe, sampled on clk.
- sel_idx  in  IDX_W  manual target index.
- tile_req  in  N_TILES  per-tile request (auto mode).
- tile_uo  in  8*N_TILES  tile outputs; tile i occupies bits [8i+7:8i].
- tile_ena  out  N_TILES  one-hot enable of the active tile.
- tile_rst_n  out  N_TILES  per-tile active-low reset.
- uo_out  out  8  registered output of the active tile.
- active_idx  out  IDX_W  index of the current or target tile.
- busy  out  1  high in SWITCH and RESET_TILE.
- sel_err  out  1  one-cycle pulse on a rejected manual load.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - tile_ena=0, tile_rst_n=0, uo_out=0, active_idx=0, busy=0, sel_err=0.
  - Dwell counter and RR pointer are cleared.
- States and transitions:
  - IDLE: all tiles disabled and held in reset. Leaves on an accepted select.
  - SWITCH: lasts 1 cycle. All ena=0, all rst_n=0. Then goes to RESET_TILE.
  - RESET_TILE: lasts RST_CYCLES cycles. tile_ena[target]=1, tile_rst_n[target]=0. Then goes to RUN.
  - RUN: tile_ena[target]=1, tile_rst_n[target]=1. Dwell counter increments, saturating at DWELL.
- Non-active tiles always have ena=0 and rst_n=0.
- active_idx updates to the target on the edge that enters SWITCH.
- uo_out:
  - Equals tile_uo[active_idx] sampled at the previous edge when the state was RUN then; otherwise 0.
  - This gives one cycle of output latency.
- Timing from a manual select:
  - sel_load sampled at edge T.
  - SWITCH during cycle T+1.
  - RESET_TILE during cycles T+2 .. T+1+RST_CYCLES.
  - RUN from T+2+RST_CYCLES.
  - First valid uo_out at T+3+RST_CYCLES.
- Manual mode (sel_mode=0):
  - sel_load with sel_idx >= N_TILES: ignored; sel_err pulses 1 cycle.
  - sel_load with sel_idx == active_idx while in RUN: no effect, no re-reset.
  - sel_load while in SWITCH or RESET_TILE: accepted; the latest target wins and the sequence restarts at SWITCH.
  - tile_req is ignored.
- Auto mode (sel_mode=1):
  - sel_load is ignored; sel_err stays 0.
  - From IDLE: the first requester at or after the RR pointer (wrapping) is selected.
  - In RUN, the next candidate is the first requester in order active_idx+1 .. wrapping, excluding active_idx.
  - Rotation: switch if the dwell counter has reached DWELL and a candidate exists.
  - Early switch: switch immediately, ignoring dwell, if tile_req[active_idx]=0 and a candidate exists.
  - No candidate: remain in RUN on the current tile, even if its own request has dropped.
  - Requests are not sampled during SWITCH or RESET_TILE.
  - The RR pointer is set to the target on every switch.
- Mode changes:
  - Auto to manual: the current tile keeps running.
  - Manual to auto: the dwell counter clears to 0.
- Dwell counter clears on entering SWITCH.
- rst asserted mid-sequence: everything returns to IDLE on that edge; no partial enable glitch follows.
- Single-bit indices and N_TILES not a power of two must be handled; out-of-range indices never enable any tile.

Test Plan:
- Reset: assert rst for 2 cycles with tile_uo all 0xAA -> tile_ena=0, tile_rst_n=0, uo_out=0x00, busy=0.
- Manual select, timing check:
  - Stimulus: sel_load with sel_idx=5, RST_CYCLES=4, tile_uo[5]=0x3C, sel_load at edge T.
  - Required: busy=1 for cycles T+1..T+5.
  - Required: tile_rst_n[5]=0 through T+5, then 1 at T+6.
  - Required: uo_out=0x3C at T+7.
- Manual reject: sel_idx=9 with N_TILES=8 -> sel_err pulses 1 cycle; active_idx and outputs unchanged.
- Retarget mid-reset: load 2, then load 6 during RESET_TILE -> SWITCH re-entered; tile 2 never reaches rst_n=1; tile 6 runs.
- Auto rotation:
  - Stimulus: tile_req=8'b0000_1011, DWELL=16.
  - Required: tile order 0 -> 1 -> 3 -> 0, each in RUN for exactly 16 cycles before SWITCH.
- Early switch and hold:
  - Drop tile_req[1] while tile 1 is in RUN with tile 3 requesting -> SWITCH on the next edge.
  - Drop all requests -> current tile remains in RUN indefinitely.
